// File: rtl/multi_ff_pkg.sv
// Shared mode encoding for the multi_ff_reg register bank.
package multi_ff_pkg;

   localparam int unsigned MODE_W = 3;

   localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;
   localparam logic [MODE_W-1:0] MODE_LOAD = 3'd1;
   localparam logic [MODE_W-1:0] MODE_JK   = 3'd2;
   localparam logic [MODE_W-1:0] MODE_TOG  = 3'd3;
   localparam logic [MODE_W-1:0] MODE_SHL  = 3'd4;
   localparam logic [MODE_W-1:0] MODE_SHR  = 3'd5;
   localparam logic [MODE_W-1:0] MODE_ROL  = 3'd6;
   localparam logic [MODE_W-1:0] MODE_CLR  = 3'd7;

endpackage

// File: rtl/ff_bit_cell.sv
// One-bit next-state function for the bitwise modes; the shift modes hold here
// and are muxed over by the top level.
module ff_bit_cell
   import multi_ff_pkg::*;
(
   input  logic [MODE_W-1:0] mode,
   input  logic              q,
   input  logic              d,
   input  logic              j,
   input  logic              k,
   output logic              nxt_c
);

   always_comb begin
      nxt_c = q;
      unique case (mode)
         MODE_LOAD: nxt_c = d;
         MODE_JK: begin
            unique case ({j, k})
               2'b01:   nxt_c = 1'b0;
               2'b10:   nxt_c = 1'b1;
               2'b11:   nxt_c = ~q;
               default: nxt_c = q;
            endcase
         end
         MODE_TOG: nxt_c = q ^ d;
         MODE_CLR: nxt_c = 1'b0;
         default:  nxt_c = q;
      endcase
   end

endmodule

// File: rtl/multi_ff_reg.sv
// Mode-selectable WIDTH-bit register bank: hold/load/JK/toggle/shift/rotate/clear
// with complementary outputs, serial out and a one-cycle change flag.
module multi_ff_reg
   import multi_ff_pkg::*;
#(
   parameter int unsigned       WIDTH   = 8,
   parameter logic [WIDTH-1:0]  RST_VAL = {WIDTH{1'b0}}
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [MODE_W-1:0] mode,
   input  logic [WIDTH-1:0]  d,
   input  logic [WIDTH-1:0]  j,
   input  logic [WIDTH-1:0]  k,
   input  logic              si,
   output logic [WIDTH-1:0]  q,
   output logic [WIDTH-1:0]  qn,
   output logic              so,
   output logic              chg
);

   logic [WIDTH-1:0] cell_nxt_c;
   logic [WIDTH-1:0] next_q_c;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      ff_bit_cell u_cell (
         .mode  (mode),
         .q     (q[i]),
         .d     (d[i]),
         .j     (j[i]),
         .k     (k[i]),
         .nxt_c (cell_nxt_c[i])
      );
   end

   // Reordering modes override the per-bit result; en low freezes everything.
   always_comb begin
      next_q_c = cell_nxt_c;
      unique case (mode)
         MODE_SHL: next_q_c = {q[WIDTH-2:0], si};
         MODE_SHR: next_q_c = {si, q[WIDTH-1:1]};
         MODE_ROL: next_q_c = {q[WIDTH-2:0], q[WIDTH-1]};
         default:  next_q_c = cell_nxt_c;
      endcase
      if (!en) next_q_c = q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q   <= RST_VAL;
         chg <= 1'b0;
      end else begin
         q   <= next_q_c;
         chg <= (next_q_c != q);
      end
   end

   assign qn = ~q;
   assign so = (mode == MODE_SHR) ? q[0] : q[WIDTH-1];

endmodule

// File: tb/tb_multi_ff_reg.sv
// Directed bench for multi_ff_reg with a behavioural reference model.
module tb_multi_ff_reg;

   localparam int unsigned W = 8;
   localparam logic [W-1:0] RV = 8'hA5;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         en = 1'b0;
   logic [2:0]   mode = 3'd0;
   logic [W-1:0] d = '0, j = '0, k = '0;
   logic         si = 1'b0;
   logic [W-1:0] q, qn;
   logic         so, chg;

   int n_chk = 0;
   int n_fail = 0;

   logic [W-1:0] m_q;
   logic         m_chg;

   multi_ff_reg #(.WIDTH(W), .RST_VAL(RV)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d), .j(j), .k(k),
      .si(si), .q(q), .qn(qn), .so(so), .chg(chg)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference next state computed from the operation rules with plain arithmetic.
   function automatic logic [W-1:0] model_next(input logic [W-1:0] cq, input logic e,
                                               input int m, input logic [W-1:0] dd,
                                               input logic [W-1:0] jj, input logic [W-1:0] kk,
                                               input logic s);
      if (!e) return cq;
      case (m)
         0: return cq;
         1: return dd;
         2: return (jj & ~cq) | (~kk & cq);
         3: return cq ^ dd;
         4: return (cq << 1) | (s ? 8'h01 : 8'h00);
         5: return (cq >> 1) | (s ? 8'h80 : 8'h00);
         6: return (cq << 1) | (cq >> 7);
         default: return 8'h00;
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      logic [W-1:0] nq;
      if (!rst_n) begin
         m_q   = RV;
         m_chg = 1'b0;
      end else begin
         nq    = model_next(m_q, en, int'(mode), d, j, k, si);
         m_chg = (nq != m_q);
         m_q   = nq;
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      check("cmp_q",   q,   m_q);
      check("cmp_qn",  qn,  ~m_q);
      check("cmp_chg", 8'(chg), 8'(m_chg));
      check("cmp_so",  8'(so),  8'((mode == 3'd5) ? m_q[0] : m_q[7]));
   end

   task automatic apply(input logic [2:0] m, input logic [W-1:0] dd, input logic [W-1:0] jj,
                        input logic [W-1:0] kk, input logic s, input logic e);
      mode = m; d = dd; j = jj; k = kk; si = s; en = e;
      @(posedge clk);
      #2;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #2;
      check("rst_q",   q,  8'hA5);
      check("rst_qn",  qn, 8'h5A);
      check("rst_chg", 8'(chg), 8'h00);
      rst_n = 1'b1;

      apply(3'd1, 8'h0F, 8'h00, 8'h00, 1'b0, 1'b1);
      check("load_q", q, 8'h0F);
      check("load_chg", 8'(chg), 8'h01);
      apply(3'd2, 8'h00, 8'hF0, 8'h3C, 1'b0, 1'b1);
      check("jk_q", q, 8'hF3);
      check("jk_chg", 8'(chg), 8'h01);

      apply(3'd1, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1);
      apply(3'd3, 8'h81, 8'h00, 8'h00, 1'b0, 1'b1);
      check("tog_q", q, 8'h7E);
      apply(3'd3, 8'h81, 8'h00, 8'h00, 1'b0, 1'b0);
      check("en0_q", q, 8'h7E);
      check("en0_chg", 8'(chg), 8'h00);
      apply(3'd1, 8'h7E, 8'h00, 8'h00, 1'b0, 1'b1);
      check("same_load_chg", 8'(chg), 8'h00);

      apply(3'd7, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         apply(3'd4, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
         check("shl_so", 8'(so), (i == 7) ? 8'h01 : 8'h00);
      end
      check("shl_q", q, 8'hFF);

      apply(3'd1, 8'h80, 8'h00, 8'h00, 1'b0, 1'b1);
      apply(3'd5, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
      check("shr_q", q, 8'h40);
      check("shr_so", 8'(so), 8'h00);

      apply(3'd1, 8'h81, 8'h00, 8'h00, 1'b0, 1'b1);
      apply(3'd6, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
      check("rol1_q", q, 8'h03);
      repeat (7) apply(3'd6, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
      check("rol8_q", q, 8'h81);
      apply(3'd7, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
      check("clr_q", q, 8'h00);
      check("clr_chg", 8'(chg), 8'h01);
      apply(3'd7, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
      check("clr2_chg", 8'(chg), 8'h00);

      repeat (3) apply(3'd4, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
      check("pre_rst_q", q, 8'h07);
      rst_n = 1'b0;
      #1;
      check("async_rst_q",   q,  8'hA5);
      check("async_rst_qn",  qn, 8'h5A);
      check("async_rst_chg", 8'(chg), 8'h00);
      #4;
      rst_n = 1'b1;
      apply(3'd4, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
      check("resume_q", q, 8'h4B);
      check("resume_chg", 8'(chg), 8'h01);

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_ff_reg.md
# multi_ff_reg

Parametrised WIDTH-bit register bank that generalises the single-bit D and JK flip-flops into one mode-selectable storage element. Each cycle it can hold, load, apply per-bit JK or T control, shift, rotate or clear. It also provides complementary outputs, a serial-out bit and a one-cycle change flag. It is the general-purpose state element for datapaths and lab exercises that previously instantiated discrete flip-flops.

## Interface
- WIDTH, 8, register width in bits; legal range is 2 or more
- RST_VAL, {WIDTH{1'b0}}, value loaded into q on reset

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  update enable; when low the register holds regardless of mode
- mode  input  3  operation select (see Operation)
- d  input  WIDTH  load data (LOAD mode); toggle mask (TOG mode)
- j  input  WIDTH  per-bit J input (JK mode)
- k  input  WIDTH  per-bit K input (JK mode)
- si  input  1  serial input for the shift modes
- q  output  WIDTH  register state
- qn  output  WIDTH  always equal to ~q
- so  output  1  serial out: q[0] when mode is SHR, otherwise q[WIDTH-1]
- chg  output  1  registered flag: high for one cycle after any edge that changed q

## Operation
- One clock domain (clk). Reset is asynchronous and active-low (rst_n).
- Reset, asserted at any time including mid-operation:
  - q = RST_VAL and qn = ~RST_VAL immediately, without waiting for a clock edge.
  - chg = 0.
  - so follows q combinationally.
- Mode encoding, applied at a rising edge when en=1:
  - 0 HOLD: q unchanged
  - 1 LOAD: q <= d
  - 2 JK: per bit i, (j,k) = 00 hold, 01 clear, 10 set, 11 toggle
  - 3 TOG: q <= q ^ d
  - 4 SHL: q <= {q[WIDTH-2:0], si}
  - 5 SHR: q <= {si, q[WIDTH-1:1]}
  - 6 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}
  - 7 CLR: q <= 0 (synchronous clear to zero, not to RST_VAL)
- en=0 behaves as HOLD for every mode; no input is sampled.
- chg is registered from (next_q != q). It stays low for HOLD or en=0, and for any operation whose result equals the current q. Examples: LOAD of identical data, TOG with d=0, CLR when q is already 0.
- X or undefined mode values are not legal and are not checked.
- No arithmetic is performed; all operations are bitwise or reordering.

## Timing
- Latency is 1 cycle: operands sampled at edge N appear on q after edge N.
- qn and so are combinational from q and mode; there is no extra cycle.
- chg asserts in the same cycle that the new q is visible and lasts exactly one cycle per changing edge. Back-to-back changes hold chg high continuously.
- Reset release: the first edge with rst_n=1 performs the selected operation normally. The reset de-assertion edge is assumed synchronous to clk at system level.
- Reset during a shift sequence discards the partial contents. No state survives reset.

## Structure
- Package multi_ff_pkg holds:
  - mode localparams MODE_HOLD, MODE_LOAD, MODE_JK, MODE_TOG, MODE_SHL, MODE_SHR, MODE_ROL, MODE_CLR
  - the 3-bit mode width
- Sub-module ff_bit_cell: a one-bit next-state function covering the HOLD, LOAD, JK, TOG and CLR terms. It is instantiated WIDTH times in a generate loop.
- Shift and rotate muxing, the state register, the chg register and output assignments live in the top level.
- Single always block for q and chg, with asynchronous reset in the sensitivity list.

## Test plan
All scenarios use WIDTH=8.
- Reset: RST_VAL=8'hA5, rst_n low mid-cycle -> q=8'hA5, qn=8'h5A and chg=0 immediately, without a clock edge.
- LOAD then JK: load d=8'h0F; next cycle j=8'hF0, k=8'h3C -> q=8'hF3 (bits 7:6 set, 5:4 toggle, 3:2 clear, 1:0 hold); chg=1 both cycles.
- TOG and en gating: q=8'hFF, TOG with d=8'h81 -> 8'h7E. Repeat with en=0 -> q stays 8'h7E and chg=0.
- Shift:
  - SHL with si=1 for 8 cycles from 8'h00 -> q=8'hFF; so sequence 0,0,0,0,0,0,0,1.
  - SHR with si=0 from 8'h80 -> 8'h40 and so=q[0]=0.
- ROL wrap: q=8'h81, ROL -> 8'h03; after 8 ROLs q returns to 8'h81. CLR -> 8'h00; second CLR -> chg=0.
- Reset mid-shift: during an SHL sequence, pulse rst_n low for half a cycle -> q=RST_VAL asynchronously; the next edge resumes shifting from RST_VAL.
